game_controller_multiball: RTL
==============================

Name: game_controller_multiball

Overview:
- Parametrised successor to the single-ball game controller in the pinball main screen.
- Tracks life, score and level. Supports NUM_BALLS simultaneous balls, a configurable level count and score target, saturating scoring, and a timed respawn.
- Sits between CollisionDetector (event inputs) and the ball/flipper/indication blocks, which consume pause, reset_level, score, level and life.
- All game events are sampled once per frame, on startOfFrame.

Parameters:
- NUM_BALLS, 2, number of balls in play; width of the per-ball vectors.
- LIVES_INIT, 3, life count after reset and after every new game.
- LIFE_W, 4, width of life.
- SCORE_W, 4, width of score and scoreNumber.
- LEVEL_W, 4, width of level.
- NUM_LEVELS, 3, levels per game; the last index is NUM_LEVELS-1.
- LEVEL_TARGET, 9, score at or above which the current level is cleared.
- BAD_PENALTY, 1, score subtracted on a bad-obstacle hit.
- RESPAWN_FRAMES, 60, frames held in BALL_LOST before SERVE.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- start  in  1  level from the screen selector; its rising edge starts a game.
- key5IsPressed  in  1  launch/pause key, level-sensitive.
- scoreNumber  in  SCORE_W  current random value of the good obstacle.
- collisionSmileyBorderBottom  in  NUM_BALLS  per-ball bottom-border hit.
- collisionSmileyObstacleGood  in  1  any ball hit the good obstacle.
- collisionSmileyObstacleBad  in  1  any ball hit the bad obstacle.
- pause  out  1  freezes ball and flipper motion.
- reset_level  out  1  holds balls and flipper at their start positions.
- reset_level_pulse  out  1  one-cycle pulse on every entry to SERVE.
- ballActive  out  NUM_BALLS  per-ball alive mask.
- score  out  SCORE_W  current level score.
- level  out  LEVEL_W  current level, 0-based.
- life  out  LIFE_W  remaining lives.
- gameOver  out  1  high in GAME_OVER.
- gameWon  out  1  high in WIN.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, pause=1, reset_level=1, reset_level_pulse=0, ballActive=0, score=0, level=0, life=LIVES_INIT, gameOver=0, gameWon=0.
- Internal edge detectors and event latches also clear on reset.
- Reset asserted mid-game returns everything to these values immediately.

Inputs:
- key5 and start use registered rising-edge detection; a held key produces exactly one edge.
- The collision inputs set sticky latches: bottom[NUM_BALLS], good, bad.
- On the cycle startOfFrame=1, the latched values are evaluated together with any inputs present in that same cycle. All latches clear in that cycle in every state.
- Events latched outside PLAY are discarded.
- Register updates take effect on the cycle after startOfFrame.

States:
- IDLE: pause=1, reset_level=1. start edge -> life=LIVES_INIT, score=0, level=0 -> SERVE.
- SERVE: on entry, reset_level_pulse=1 for exactly one cycle and ballActive=all 1. pause=1, reset_level=1. key5 edge -> PLAY.
- PLAY: pause=0, reset_level=0. key5 edge -> PAUSE. Frame evaluation order:
  1. Score update: next = score + (good ? scoreNumber : 0) - (bad ? BAD_PENALTY : 0). Compute in SCORE_W+2 signed arithmetic, then saturate to [0, 2^SCORE_W-1].
  2. ballActive &= ~bottom.
  3. If ballActive becomes 0: life is decremented. If the new life is 0 -> GAME_OVER; otherwise -> BALL_LOST.
  4. Otherwise, if the new score >= LEVEL_TARGET: at level == NUM_LEVELS-1 -> WIN; otherwise level+1, score=0 -> SERVE.
  - Ball loss takes priority over level clear in the same frame.
  - A key5 edge and a frame event in the same cycle: the frame event wins; the key5 edge is dropped.
- PAUSE: pause=1, reset_level=0, all counters frozen. key5 edge -> PLAY.
- BALL_LOST: pause=1, reset_level=1. A frame counter counts startOfFrame pulses from 0; at RESPAWN_FRAMES-1 -> SERVE. Score and level are kept.
- GAME_OVER: gameOver=1, pause=1, reset_level=1. start edge -> new game, as from IDLE.
- WIN: gameWon=1, pause=1, reset_level=1. start edge -> new game, as from IDLE.

Other rules:
- life never underflows.
- level never exceeds NUM_LEVELS-1.
- The start edge is ignored in SERVE, PLAY, PAUSE and BALL_LOST.

Test Plan:
- Reset, then start edge -> SERVE, reset_level_pulse one cycle, ballActive=2'b11, life=3. key5 edge -> PLAY, pause=0.
- In PLAY with score=7, good hit with scoreNumber=5 on one frame -> score=12 next cycle ≥9 -> level=1, score=0, SERVE. Same with score=14, scoreNumber=5, SCORE_W=4 -> saturates at 15.
- Ball 0 bottom hit in frame N -> ballActive=2'b10, life=3. Ball 1 bottom hit in frame N+1 -> life=2, BALL_LOST. Exactly 60 startOfFrame pulses later -> SERVE.
- Score=0, bad hit -> score stays 0. Good (scoreNumber=3) and bad in the same frame -> score=2.
- life=1, both balls hit bottom in the same frame as a good hit reaching 9 -> life=0, GAME_OVER, gameOver=1, level unchanged. start edge -> life=3, level=0.
- key5 held for 10 frames in PLAY -> a single PAUSE entry; collisions during PAUSE are ignored. resetN pulsed low mid-PLAY -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/game_controller_multiball.sv
// Multi-ball pinball game controller: tracks lives, score and level, and sequences
// serve / play / pause / respawn / end-of-game using events sampled once per frame.
module game_controller_multiball #(
    parameter int NUM_BALLS      = 2,
    parameter int LIVES_INIT     = 3,
    parameter int LIFE_W         = 4,
    parameter int SCORE_W        = 4,
    parameter int LEVEL_W        = 4,
    parameter int NUM_LEVELS     = 3,
    parameter int LEVEL_TARGET   = 9,
    parameter int BAD_PENALTY    = 1,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 start,
    input  logic                 key5IsPressed,
    input  logic [SCORE_W-1:0]   scoreNumber,
    input  logic [NUM_BALLS-1:0] collisionSmileyBorderBottom,
    input  logic                 collisionSmileyObstacleGood,
    input  logic                 collisionSmileyObstacleBad,
    output logic                 pause,
    output logic                 reset_level,
    output logic                 reset_level_pulse,
    output logic [NUM_BALLS-1:0] ballActive,
    output logic [SCORE_W-1:0]   score,
    output logic [LEVEL_W-1:0]   level,
    output logic [LIFE_W-1:0]    life,
    output logic                 gameOver,
    output logic                 gameWon
);

    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_PLAY, S_PAUSE, S_BALL_LOST, S_GAME_OVER, S_WIN
    } state_t;

    localparam int CNT_W = $clog2(RESPAWN_FRAMES + 1);
    localparam int SUM_W = SCORE_W + 2;
    localparam logic signed [SUM_W-1:0] SCORE_MAX  = SUM_W'((1 << SCORE_W) - 1);
    localparam logic [LEVEL_W-1:0]      LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0]        LAST_FRAME = CNT_W'(RESPAWN_FRAMES - 1);

    state_t                 r_state;
    logic                   r_startPrev, r_key5Prev;
    logic [NUM_BALLS-1:0]   r_bottomLatch;
    logic                   r_goodLatch, r_badLatch;
    logic [CNT_W-1:0]       r_frameCnt;
    logic                   r_pause, r_resetLevel, r_resetLevelPulse, r_gameOver, r_gameWon;
    logic [NUM_BALLS-1:0]   r_ballActive;
    logic [SCORE_W-1:0]     r_score;
    logic [LEVEL_W-1:0]     r_level;
    logic [LIFE_W-1:0]      r_life;

    logic                   w_startEdge, w_key5Edge;
    logic [NUM_BALLS-1:0]   w_bottom, w_activeNext;
    logic                   w_good, w_bad, w_levelClear;
    logic signed [SUM_W-1:0] w_addend, w_penalty, w_sum;
    logic [SCORE_W-1:0]     w_scoreSat;
    logic [LIFE_W-1:0]      w_lifeDec;
    state_t                 w_nextState;

    assign w_startEdge = start & ~r_startPrev;
    assign w_key5Edge  = key5IsPressed & ~r_key5Prev;

    // Frame evaluation merges latched events with same-cycle inputs; ball loss beats level clear.
    always_comb begin
        w_bottom     = r_bottomLatch | collisionSmileyBorderBottom;
        w_good       = r_goodLatch | collisionSmileyObstacleGood;
        w_bad        = r_badLatch | collisionSmileyObstacleBad;
        w_addend     = w_good ? {2'b00, scoreNumber} : '0;
        w_penalty    = w_bad ? SUM_W'(BAD_PENALTY) : '0;
        w_sum        = $signed({2'b00, r_score}) + w_addend - w_penalty;
        if (w_sum[SUM_W-1])
            w_scoreSat = '0;
        else if (w_sum > SCORE_MAX)
            w_scoreSat = '1;
        else
            w_scoreSat = w_sum[SCORE_W-1:0];
        w_activeNext = r_ballActive & ~w_bottom;
        w_lifeDec    = (r_life != '0) ? r_life - 1'b1 : '0;
        w_levelClear = ({2'b00, w_scoreSat} >= SUM_W'(LEVEL_TARGET));

        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_GAME_OVER, S_WIN:
                if (w_startEdge) w_nextState = S_SERVE;
            S_SERVE:
                if (w_key5Edge) w_nextState = S_PLAY;
            S_PLAY: begin
                if (startOfFrame) begin
                    if (w_activeNext == '0)
                        w_nextState = (w_lifeDec == '0) ? S_GAME_OVER : S_BALL_LOST;
                    else if (w_levelClear)
                        w_nextState = (r_level == LAST_LEVEL) ? S_WIN : S_SERVE;
                end else if (w_key5Edge) begin
                    w_nextState = S_PAUSE;
                end
            end
            S_PAUSE:
                if (w_key5Edge) w_nextState = S_PLAY;
            S_BALL_LOST:
                if (startOfFrame && r_frameCnt == LAST_FRAME) w_nextState = S_SERVE;
            default:
                w_nextState = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change together with it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state           <= S_IDLE;
            r_startPrev       <= 1'b0;
            r_key5Prev        <= 1'b0;
            r_bottomLatch     <= '0;
            r_goodLatch       <= 1'b0;
            r_badLatch        <= 1'b0;
            r_frameCnt        <= '0;
            r_pause           <= 1'b1;
            r_resetLevel      <= 1'b1;
            r_resetLevelPulse <= 1'b0;
            r_gameOver        <= 1'b0;
            r_gameWon         <= 1'b0;
            r_ballActive      <= '0;
            r_score           <= '0;
            r_level           <= '0;
            r_life            <= LIFE_W'(LIVES_INIT);
        end else begin
            r_startPrev       <= start;
            r_key5Prev        <= key5IsPressed;
            r_state           <= w_nextState;
            r_pause           <= (w_nextState != S_PLAY);
            r_resetLevel      <= !(w_nextState == S_PLAY || w_nextState == S_PAUSE);
            r_gameOver        <= (w_nextState == S_GAME_OVER);
            r_gameWon         <= (w_nextState == S_WIN);
            r_resetLevelPulse <= (w_nextState == S_SERVE) && (r_state != S_SERVE);

            if (startOfFrame || r_state != S_PLAY) begin
                r_bottomLatch <= '0;
                r_goodLatch   <= 1'b0;
                r_badLatch    <= 1'b0;
            end else begin
                r_bottomLatch <= w_bottom;
                r_goodLatch   <= w_good;
                r_badLatch    <= w_bad;
            end

            if (r_state != S_BALL_LOST)
                r_frameCnt <= '0;
            else if (startOfFrame)
                r_frameCnt <= r_frameCnt + 1'b1;

            case (r_state)
                S_IDLE, S_GAME_OVER, S_WIN: begin
                    if (w_startEdge) begin
                        r_life  <= LIFE_W'(LIVES_INIT);
                        r_score <= '0;
                        r_level <= '0;
                    end
                end
                S_PLAY: begin
                    if (startOfFrame) begin
                        r_score      <= w_scoreSat;
                        r_ballActive <= w_activeNext;
                        if (w_activeNext == '0) begin
                            r_life <= w_lifeDec;
                        end else if (w_levelClear && r_level != LAST_LEVEL) begin
                            r_level <= r_level + 1'b1;
                            r_score <= '0;
                        end
                    end
                end
                default: ;
            endcase

            // Every serve puts a full set of balls back in play.
            if (w_nextState == S_SERVE && r_state != S_SERVE)
                r_ballActive <= '1;
        end
    end

    assign pause             = r_pause;
    assign reset_level       = r_resetLevel;
    assign reset_level_pulse = r_resetLevelPulse;
    assign ballActive        = r_ballActive;
    assign score             = r_score;
    assign level             = r_level;
    assign life              = r_life;
    assign gameOver          = r_gameOver;
    assign gameWon           = r_gameWon;

endmodule
